// File: rtl/aes_state_banks_if.sv
// Command, response and external S-box signals of aes_state_banks, grouped into one bundle.
interface aes_state_banks_if #(
    parameter int BW = 1
);
    logic          cs;
    logic [2:0]    op;
    logic [BW-1:0] bank;
    logic [3:0]    addr;
    logic [7:0]    data_in;
    logic [127:0]  key;
    logic [7:0]    data_out;
    logic          busy;
    logic          done;
    logic [7:0]    sb_addr;
    logic [7:0]    sb_data;

    modport master (
        output cs, op, bank, addr, data_in, key, sb_data,
        input  data_out, busy, done, sb_addr
    );
    modport slave (
        input  cs, op, bank, addr, data_in, key, sb_data,
        output data_out, busy, done, sb_addr
    );
endinterface

// File: rtl/aes_state_banks.sv
// Banks of 16-byte AES states with single-edge round transforms and a
// 16-cycle SubBytes sequencer that uses an external combinational S-box.
module aes_state_banks #(
    parameter int NBANK = 2,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    aes_state_banks_if.slave bus
);
    typedef logic [15:0][7:0] blk_t;   // byte i holds s[i%4][i/4]
    typedef enum logic {IDLE, SUB} state_t;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_MIX   = 3'd4;
    localparam logic [2:0] OP_ARK   = 3'd5;
    localparam logic [2:0] OP_ISHR  = 3'd6;
    localparam logic [2:0] OP_COPY  = 3'd7;

    function automatic blk_t shift_rows(blk_t s, logic inv);
        blk_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = inv ? s[4*((c - r + 4) % 4) + r] : s[4*((c + r) % 4) + r];
        return o;
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t mix_columns(blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic blk_t add_key(blk_t s, logic [127:0] key);
        blk_t o;
        for (int i = 0; i < 16; i++)
            o[i] = s[i] ^ key[127-8*i -: 8];
        return o;
    endfunction

    blk_t          mem_q [NBANK];
    blk_t          mem_d [NBANK];
    state_t        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [BW-1:0] sub_bank_q, sub_bank_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          done_q, done_d;
    logic [BW-1:0] dest;
    logic          bank_ok, dest_ok;

    assign dest    = bus.addr[BW-1:0];
    assign bank_ok = 32'(bus.bank) < NBANK;
    assign dest_ok = 32'(dest) < NBANK;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        mem_d      = mem_q;
        state_d    = state_q;
        k_d        = k_q;
        sub_bank_d = sub_bank_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cs && bank_ok) begin
                    case (bus.op)
                        OP_READ:  data_out_d = mem_q[bus.bank][bus.addr];
                        OP_WRITE: mem_d[bus.bank][bus.addr] = bus.data_in;
                        OP_SUB: begin
                            state_d    = SUB;
                            k_d        = 4'd0;
                            sub_bank_d = bus.bank;
                        end
                        OP_SHR: begin
                            mem_d[bus.bank] = shift_rows(mem_q[bus.bank], 1'b0);
                            done_d          = 1'b1;
                        end
                        OP_MIX: begin
                            mem_d[bus.bank] = mix_columns(mem_q[bus.bank]);
                            done_d          = 1'b1;
                        end
                        OP_ARK: begin
                            mem_d[bus.bank] = add_key(mem_q[bus.bank], bus.key);
                            done_d          = 1'b1;
                        end
                        OP_ISHR: begin
                            mem_d[bus.bank] = shift_rows(mem_q[bus.bank], 1'b1);
                            done_d          = 1'b1;
                        end
                        OP_COPY: begin
                            if (dest_ok) begin
                                mem_d[dest] = mem_q[bus.bank];
                                done_d      = 1'b1;
                            end
                        end
                    endcase
                end
            end
            SUB: begin
                // Bytes below k already hold S-box output; byte k is substituted this edge.
                mem_d[sub_bank_q][k_q] = bus.sb_data;
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            // NOTE: the state banks are architecturally visible, so they are cleared on reset like any flop.
            for (int b = 0; b < NBANK; b++) mem_q[b] <= '0;
            state_q    <= IDLE;
            k_q        <= 4'd0;
            sub_bank_q <= '0;
            data_out_q <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            k_q        <= k_d;
            sub_bank_q <= sub_bank_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q == SUB);
    assign bus.sb_addr  = (state_q == SUB) ? mem_q[sub_bank_q][k_q] : 8'h00;
endmodule

// File: tb/tb_aes_state_banks.sv
// Self-checking bench: FIPS-197 vectors plus randomized commands against a byte-array model.
module tb_aes_state_banks;
    localparam int NBANK = 3;
    localparam int BW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_state_banks_if #(.BW(BW)) ifc ();
    aes_state_banks #(.NBANK(NBANK), .BW(BW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc)
    );

    logic [7:0] sbox_tbl [256];
    assign ifc.sb_data = sbox_tbl[ifc.sb_addr];

    // Reference model: plain byte arrays; SubBytes result is computed at once and
    // becomes visible after 16 busy cycles.
    logic [7:0] m_mem [NBANK][16];
    logic [7:0] m_dout = 8'h00;
    logic       m_done = 1'b0;
    int         sub_left = 0;
    int         sub_bank = 0;
    logic [7:0] sub_orig [16];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            for (int b = 0; b < NBANK; b++)
                for (int i = 0; i < 16; i++) m_mem[b][i] <= 8'h00;
            m_dout   <= 8'h00;
            sub_left <= 0;
        end else if (sub_left > 0) begin
            sub_left <= sub_left - 1;
            if (sub_left == 1) begin
                for (int i = 0; i < 16; i++) m_mem[sub_bank][i] <= sbox_tbl[sub_orig[i]];
                m_done <= 1'b1;
            end
        end else if (ifc.cs && int'(ifc.bank) < NBANK) begin
            case (ifc.op)
                3'd0: m_dout <= m_mem[ifc.bank][ifc.addr];
                3'd1: m_mem[ifc.bank][ifc.addr] <= ifc.data_in;
                3'd2: begin
                    sub_left <= 16;
                    sub_bank <= int'(ifc.bank);
                    for (int i = 0; i < 16; i++) sub_orig[i] <= m_mem[ifc.bank][i];
                end
                3'd3, 3'd6: begin
                    for (int c = 0; c < 4; c++)
                        for (int r = 0; r < 4; r++)
                            m_mem[ifc.bank][4*c+r] <=
                                m_mem[ifc.bank][4*((c + (ifc.op == 3'd3 ? r : 4 - r)) % 4) + r];
                    m_done <= 1'b1;
                end
                3'd4: begin
                    for (int c = 0; c < 4; c++)
                        for (int r = 0; r < 4; r++)
                            m_mem[ifc.bank][4*c+r] <=
                                gf_mul(8'h02, m_mem[ifc.bank][4*c + r]) ^
                                gf_mul(8'h03, m_mem[ifc.bank][4*c + (r+1)%4]) ^
                                m_mem[ifc.bank][4*c + (r+2)%4] ^
                                m_mem[ifc.bank][4*c + (r+3)%4];
                    m_done <= 1'b1;
                end
                3'd5: begin
                    for (int i = 0; i < 16; i++)
                        m_mem[ifc.bank][i] <= m_mem[ifc.bank][i] ^ ifc.key[127-8*i -: 8];
                    m_done <= 1'b1;
                end
                3'd7: begin
                    if (int'(ifc.addr[BW-1:0]) < NBANK) begin
                        for (int i = 0; i < 16; i++) m_mem[ifc.addr[BW-1:0]][i] <= m_mem[ifc.bank][i];
                        m_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", ifc.data_out, m_dout);
            check("busy", ifc.busy, sub_left > 0);
            check("done", ifc.done, m_done);
            check("sb_addr", ifc.sb_addr, (sub_left > 0) ? sub_orig[4'(16 - sub_left)] : 8'h00);
        end
    end

    task automatic step(input logic cs, input logic [2:0] op, input logic [BW-1:0] bank,
                        input logic [3:0] addr, input logic [7:0] din);
        ifc.cs      = cs;
        ifc.op      = op;
        ifc.bank    = bank;
        ifc.addr    = addr;
        ifc.data_in = din;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, '0, 4'd0, 8'h00);
    endtask

    task automatic write_block(input logic [BW-1:0] bank, input logic [127:0] vec);
        for (int i = 0; i < 16; i++) step(1'b1, 3'd1, bank, 4'(i), vec[127-8*i -: 8]);
    endtask

    task automatic read_expect(input logic [BW-1:0] bank, input logic [127:0] vec, input string name);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 3'd0, bank, 4'(i), 8'h00);
            check($sformatf("%s[%0d]", name, i), ifc.data_out, vec[127-8*i -: 8]);
        end
    endtask

    localparam logic [127:0] V_INC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V_ARK = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SUB = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V_SHR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;

    initial begin
        int cycles;
        logic [7:0] inv;
        ifc.cs = 1'b0; ifc.op = 3'd0; ifc.bank = '0; ifc.addr = 4'd0;
        ifc.data_in = 8'h00; ifc.key = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        check("sbox_00", sbox_tbl[0], 8'h63);
        check("sbox_53", sbox_tbl[8'h53], 8'hed);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_dout", ifc.data_out, 8'h00);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_done", ifc.done, 1'b0);
        check("rst_sb_addr", ifc.sb_addr, 8'h00);

        write_block(2'd0, V_INC);
        read_expect(2'd0, V_INC, "rd_inc");
        step(1'b1, 3'd0, 2'd1, 4'd5, 8'h00);
        check("rd_bank1", ifc.data_out, 8'h00);

        write_block(2'd0, V_PT);
        ifc.key = V_KEY;
        step(1'b1, 3'd5, 2'd0, 4'd0, 8'h00);
        check("ark_done", ifc.done, 1'b1);
        idle();
        check("ark_done_once", ifc.done, 1'b0);
        read_expect(2'd0, V_ARK, "ark");

        step(1'b1, 3'd2, 2'd0, 4'd0, 8'h00);
        cycles = 0;
        for (int t = 0; t < 40 && ifc.busy; t++) begin
            cycles++;
            if (t == 0) step(1'b1, 3'd1, 2'd0, 4'd0, 8'haa);
            else        step(1'b1, 3'd0, 2'd1, 4'd0, 8'h00);
        end
        check("sub_busy_cycles", cycles, 16);
        check("sub_done", ifc.done, 1'b1);
        read_expect(2'd0, V_SUB, "sub");

        step(1'b1, 3'd3, 2'd0, 4'd0, 8'h00);
        read_expect(2'd0, V_SHR, "shr");
        step(1'b1, 3'd4, 2'd0, 4'd0, 8'h00);
        read_expect(2'd0, V_MIX, "mix");
        step(1'b1, 3'd3, 2'd0, 4'd0, 8'h00);
        step(1'b1, 3'd6, 2'd0, 4'd0, 8'h00);
        read_expect(2'd0, V_MIX, "shr_inv");

        step(1'b1, 3'd7, 2'd0, 4'd1, 8'h00);
        check("copy_done", ifc.done, 1'b1);
        ifc.key = '1;
        step(1'b1, 3'd5, 2'd1, 4'd0, 8'h00);
        read_expect(2'd1, ~V_MIX, "copy_not");
        read_expect(2'd0, V_MIX, "copy_src");

        step(1'b1, 3'd5, 2'd3, 4'd0, 8'h00);
        check("oob_bank_done", ifc.done, 1'b0);
        step(1'b1, 3'd7, 2'd0, 4'd3, 8'h00);
        check("oob_dest_done", ifc.done, 1'b0);
        read_expect(2'd0, V_MIX, "oob_keep");

        step(1'b1, 3'd2, 2'd0, 4'd0, 8'h00);
        repeat (7) idle();
        check("k7_sb_addr", ifc.sb_addr, 8'h9a);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("abort_busy", ifc.busy, 1'b0);
        check("abort_done", ifc.done, 1'b0);
        idle();
        check("abort_done_later", ifc.done, 1'b0);
        read_expect(2'd0, 128'h0, "abort_zero");

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            ifc.key = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        rst = 1'b0;
        repeat (20) idle();
        for (int b = 0; b < NBANK; b++)
            for (int i = 0; i < 16; i++) step(1'b1, 3'd0, 2'(b), 4'(i), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
